// File: rtl/sniffer_pkg.sv
// Shared types and constants for the sniffer MAC filter datapath.
package sniffer_pkg;
  typedef logic [47:0] mac_t;
  typedef logic [5:0]  mac_mask_t;

  localparam int MAC_WIN_WORDS = 3;
  localparam int MAC_OFFSETS   = 4;
  localparam int MAC_BYTES     = 6;
  localparam int WIN_BITS      = 32 * MAC_WIN_WORDS;
endpackage

// File: rtl/mac_filter_entry.sv
// One filter table entry: holds enable/address (and byte mask when
// MAC_FILTER_MASK_EN is defined) and compares it against every byte offset
// of the 96-bit window, reporting a hit and the lowest hitting offset.
module mac_filter_entry
  import sniffer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  mac_t                cfg_mac,
  input  logic                cfg_en,
`ifdef MAC_FILTER_MASK_EN
  input  mac_mask_t           cfg_mask,
`endif
  input  logic [WIN_BITS-1:0] window,
  input  logic                win_valid,
  output logic                hit,
  output logic [1:0]          offset
);

  logic      en_q;
  mac_t      mac_q;
  mac_mask_t eff_mask;
  mac_t      cand;
  mac_mask_t byte_ok;

`ifdef MAC_FILTER_MASK_EN
  mac_mask_t mask_q;

  // Entry registers; a write lands at the edge so the same-cycle compare sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      mac_q  <= '0;
      mask_q <= '1;
    end else if (cfg_we) begin
      en_q   <= cfg_en;
      mac_q  <= cfg_mac;
      mask_q <= cfg_mask;
    end
  end

  assign eff_mask = mask_q;
`else
  // Entry registers; a write lands at the edge so the same-cycle compare sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= 1'b0;
      mac_q <= '0;
    end else if (cfg_we) begin
      en_q  <= cfg_en;
      mac_q <= cfg_mac;
    end
  end

  assign eff_mask = '1;
`endif

  // Compare every alignment; scanning from the highest offset down leaves the lowest hit.
  always_comb begin
    hit     = 1'b0;
    offset  = '0;
    cand    = '0;
    byte_ok = '0;
    for (int k = MAC_OFFSETS - 1; k >= 0; k--) begin
      cand = window[WIN_BITS-1-8*k -: 48];
      for (int b = 0; b < MAC_BYTES; b++) begin
        byte_ok[b] = !eff_mask[b] || (cand[8*b +: 8] == mac_q[8*b +: 8]);
      end
      // An all-zero mask would otherwise match everything, so it never hits.
      if (en_q && win_valid && (eff_mask != '0) && (&byte_ok)) begin
        hit    = 1'b1;
        offset = 2'(k);
      end
    end
  end

endmodule

// File: rtl/mac_filter_bank.sv
// Multi-entry MAC address filter over a 32-bit byte stream. Keeps a
// three-word window, forwards the oldest word with per-entry match flags
// once a fourth word arrives, and accumulates sticky hit bits.
// Optional feature: define MAC_FILTER_MASK_EN for per-byte compare masks.
// Handshake: in_valid alone qualifies data_in (no backpressure); out_valid
// is a one-cycle strobe qualifying data_out and all match fields.
module mac_filter_bank
  import sniffer_pkg::*;
#(
  parameter int NUM_MACS = 4,
  parameter int IDX_W    = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [31:0]         data_in,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  mac_t                cfg_mac,
  input  logic                cfg_en,
`ifdef MAC_FILTER_MASK_EN
  input  mac_mask_t           cfg_mask,
`endif
  output logic                out_valid,
  output logic [31:0]         data_out,
  output logic                match,
  output logic [NUM_MACS-1:0] match_vec,
  output logic [IDX_W-1:0]    match_idx,
  output logic [1:0]          match_offset,
  output logic [NUM_MACS-1:0] sticky_hit
);

  logic [31:0]         w0, w1, w2;
  logic [2:0]          wv;
  logic [NUM_MACS-1:0] hit_vec;
  logic [1:0]          hit_off [NUM_MACS];
  logic [IDX_W-1:0]    sel_idx;
  logic [1:0]          sel_off;

  for (genvar e = 0; e < NUM_MACS; e++) begin : g_entry
    mac_filter_entry u_entry (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we && (cfg_idx == IDX_W'(e))),
      .cfg_mac   (cfg_mac),
      .cfg_en    (cfg_en),
`ifdef MAC_FILTER_MASK_EN
      .cfg_mask  (cfg_mask),
`endif
      .window    ({w2, w1, w0}),
      .win_valid (&wv),
      .hit       (hit_vec[e]),
      .offset    (hit_off[e])
    );
  end

  // Priority encoder: lowest hitting entry supplies the index and offset.
  always_comb begin
    sel_idx = '0;
    sel_off = '0;
    for (int e = NUM_MACS - 1; e >= 0; e--) begin
      if (hit_vec[e]) begin
        sel_idx = IDX_W'(e);
        sel_off = hit_off[e];
      end
    end
  end

  // Window shift and registered output; clear wins over an incoming word.
  always_ff @(posedge clk) begin
    if (rst) begin
      w0           <= '0;
      w1           <= '0;
      w2           <= '0;
      wv           <= '0;
      out_valid    <= 1'b0;
      data_out     <= '0;
      match        <= 1'b0;
      match_vec    <= '0;
      match_idx    <= '0;
      match_offset <= '0;
      sticky_hit   <= '0;
    end else if (clear) begin
      wv           <= '0;
      out_valid    <= 1'b0;
      match        <= 1'b0;
      match_vec    <= '0;
      match_idx    <= '0;
      match_offset <= '0;
      sticky_hit   <= '0;
    end else begin
      out_valid    <= 1'b0;
      match        <= 1'b0;
      match_vec    <= '0;
      match_idx    <= '0;
      match_offset <= '0;
      if (in_valid) begin
        w0 <= data_in;
        w1 <= w0;
        w2 <= w1;
        wv <= {wv[1:0], 1'b1};
        if (wv[2]) begin
          out_valid    <= 1'b1;
          data_out     <= w2;
          match        <= |hit_vec;
          match_vec    <= hit_vec;
          match_idx    <= sel_idx;
          match_offset <= sel_off;
          sticky_hit   <= sticky_hit | hit_vec;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_filter_bank.sv
// Testbench for mac_filter_bank: directed vector table followed by
// randomized traffic checked against a queue-based reference model.
module tb_mac_filter_bank;

  localparam int N  = 4;
  localparam int IW = 2;

`ifdef MAC_FILTER_MASK_EN
  localparam logic [3:0] E_MASK_VEC = 4'b1000;
  localparam logic [1:0] E_MASK_IDX = 2'd3;
  localparam logic [3:0] E_MASK_ST  = 4'b1000;
`else
  localparam logic [3:0] E_MASK_VEC = 4'b0000;
  localparam logic [1:0] E_MASK_IDX = 2'd0;
  localparam logic [3:0] E_MASK_ST  = 4'b0000;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   data_in = '0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [47:0]   cfg_mac = '0;
  logic          cfg_en = 1'b0;
`ifdef MAC_FILTER_MASK_EN
  logic [5:0]    cfg_mask = 6'h3f;
`endif
  logic          out_valid;
  logic [31:0]   data_out;
  logic          match;
  logic [N-1:0]  match_vec;
  logic [IW-1:0] match_idx;
  logic [1:0]    match_offset;
  logic [N-1:0]  sticky_hit;

  always #5 clk = ~clk;

  mac_filter_bank #(.NUM_MACS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_mac      (cfg_mac),
    .cfg_en       (cfg_en),
`ifdef MAC_FILTER_MASK_EN
    .cfg_mask     (cfg_mask),
`endif
    .out_valid    (out_valid),
    .data_out     (data_out),
    .match        (match),
    .match_vec    (match_vec),
    .match_idx    (match_idx),
    .match_offset (match_offset),
    .sticky_hit   (sticky_hit)
  );

  // ---------------- vector record ----------------
  typedef struct packed {
    logic        rst;
    logic        clr;
    logic        iv;
    logic [31:0] data;
    logic        we;
    logic [1:0]  idx;
    logic [47:0] mac;
    logic        en;
    logic [5:0]  mask;
    logic [1:0]  mode;   // 0 none, 1 valid+sticky, 2 full, 3 valid+data+sticky
    logic        ev;
    logic [31:0] edata;
    logic [3:0]  evec;
    logic [1:0]  eidx;
    logic [1:0]  eoff;
    logic [3:0]  est;
  } vec_t;

  vec_t tq[$];
  int   checks = 0;
  int   failures = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_win[$];          // accepted words since clear, oldest first
  logic [47:0] m_mac  [N];
  logic        m_en   [N];
  logic [5:0]  m_mask [N];
  logic        m_valid;
  logic [31:0] m_data;
  logic [N-1:0] m_vec;
  logic [1:0]  m_idx;
  logic [1:0]  m_off;
  logic [N-1:0] m_sticky;

  function automatic logic entry_hits(input int e, input logic [95:0] s, input int k);
    logic [47:0] cand;
    cand = s[95-8*k -: 48];
    if (!m_en[e] || m_mask[e] == 6'd0) return 1'b0;
    for (int b = 0; b < 6; b++)
      if (m_mask[e][b] && cand[8*b +: 8] != m_mac[e][8*b +: 8]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input vec_t v);
    logic [95:0] s;
    logic found;
    if (v.rst) begin
      m_win.delete();
      for (int e = 0; e < N; e++) begin m_mac[e] = '0; m_en[e] = 1'b0; m_mask[e] = 6'h3f; end
      m_valid = 0; m_data = '0; m_vec = '0; m_idx = '0; m_off = '0; m_sticky = '0;
    end else begin
      m_valid = 0; m_vec = '0; m_idx = '0; m_off = '0;
      if (v.clr) begin
        m_win.delete();
        m_sticky = '0;
      end else if (v.iv) begin
        if (m_win.size() == 3) begin
          s = {m_win[0], m_win[1], m_win[2]};
          m_valid = 1'b1;
          m_data = m_win[0];
          found = 1'b0;
          for (int e = 0; e < N; e++) begin
            for (int k = 0; k < 4; k++) begin
              if (!m_vec[e] && entry_hits(e, s, k)) begin
                m_vec[e] = 1'b1;
                if (!found) begin m_idx = 2'(e); m_off = 2'(k); found = 1'b1; end
              end
            end
          end
          m_sticky = m_sticky | m_vec;
          void'(m_win.pop_front());
        end
        m_win.push_back(v.data);
      end
      if (v.we) begin
        m_mac[v.idx] = v.mac;
        m_en[v.idx]  = v.en;
`ifdef MAC_FILTER_MASK_EN
        m_mask[v.idx] = v.mask;
`else
        m_mask[v.idx] = 6'h3f;
`endif
      end
    end
  endtask

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; clear = v.clr; in_valid = v.iv; data_in = v.data;
    cfg_we = v.we; cfg_idx = v.idx; cfg_mac = v.mac; cfg_en = v.en;
`ifdef MAC_FILTER_MASK_EN
    cfg_mask = v.mask;
`endif
    model_step(v);
    @(posedge clk);
    #1;
  endtask

  task automatic check_row(input vec_t v, input int r);
    if (v.mode != 2'd0) begin
      check($sformatf("row%0d out_valid", r), 64'(out_valid), 64'(v.ev));
      check($sformatf("row%0d sticky_hit", r), 64'(sticky_hit), 64'(v.est));
    end
    if (v.mode == 2'd2 || v.mode == 2'd3)
      check($sformatf("row%0d data_out", r), 64'(data_out), 64'(v.edata));
    if (v.mode == 2'd2) begin
      check($sformatf("row%0d match", r), 64'(match), 64'(v.ev && (v.evec != 4'd0)));
      check($sformatf("row%0d match_vec", r), 64'(match_vec), 64'(v.evec));
      check($sformatf("row%0d match_idx", r), 64'(match_idx), 64'(v.eidx));
      check($sformatf("row%0d match_offset", r), 64'(match_offset), 64'(v.eoff));
    end
  endtask

  task automatic check_model(input int c);
    check($sformatf("rnd%0d out_valid", c), 64'(out_valid), 64'(m_valid));
    check($sformatf("rnd%0d data_out", c), 64'(data_out), 64'(m_data));
    check($sformatf("rnd%0d sticky_hit", c), 64'(sticky_hit), 64'(m_sticky));
    check($sformatf("rnd%0d match", c), 64'(match), 64'(m_valid && (m_vec != '0)));
    if (m_valid) begin
      check($sformatf("rnd%0d match_vec", c), 64'(match_vec), 64'(m_vec));
      check($sformatf("rnd%0d match_idx", c), 64'(match_idx), 64'(m_idx));
      check($sformatf("rnd%0d match_offset", c), 64'(match_offset), 64'(m_off));
    end
  endtask

  // ---------------- vector builders ----------------
  function automatic vec_t idle_v();
    vec_t v = '0;
    v.mask = 6'h3f;
    return v;
  endfunction

  function automatic vec_t rst_v();
    vec_t v = idle_v();
    v.rst = 1'b1;
    return v;
  endfunction

  function automatic vec_t clr_v();
    vec_t v = idle_v();
    v.clr = 1'b1;
    return v;
  endfunction

  function automatic vec_t w(input logic [31:0] d);
    vec_t v = idle_v();
    v.iv = 1'b1;
    v.data = d;
    return v;
  endfunction

  function automatic vec_t cfg_v(input logic [1:0] idx, input logic [47:0] mac,
                                 input logic en, input logic [5:0] mask);
    vec_t v = idle_v();
    v.we = 1'b1; v.idx = idx; v.mac = mac; v.en = en; v.mask = mask;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input logic [1:0] mode, input logic ev,
                              input logic [31:0] edata, input logic [3:0] evec,
                              input logic [1:0] eidx, input logic [1:0] eoff,
                              input logic [3:0] est);
    vec_t v = vi;
    v.mode = mode; v.ev = ev; v.edata = edata; v.evec = evec;
    v.eidx = eidx; v.eoff = eoff; v.est = est;
    return v;
  endfunction

  // ---------------- random stream generator ----------------
  logic [47:0] pool [4];
  logic [7:0]  byte_q[$];

  function automatic logic [31:0] next_word();
    logic [47:0] m;
    logic [31:0] wd;
    while (byte_q.size() < 4) begin
      if ($urandom_range(0, 2) == 0) begin
        m = pool[$urandom_range(0, 3)];
        for (int b = 5; b >= 0; b--) byte_q.push_back(m[8*b +: 8]);
      end else begin
        byte_q.push_back(8'($urandom_range(0, 255)));
      end
    end
    wd = '0;
    for (int b = 0; b < 4; b++) wd = {wd[23:0], byte_q.pop_front()};
    return wd;
  endfunction

  function automatic logic [5:0] rnd_mask();
    case ($urandom_range(0, 5))
      0: return 6'h3f;
      1: return 6'h38;
      2: return 6'h3c;
      3: return 6'h07;
      4: return 6'h00;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    vec_t v;

    // Reset and idle
    tq.push_back(ex(rst_v(), 2, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(rst_v(), 2, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(idle_v(), 2, 0, 0, 0, 0, 0, 0));
    // Disabled entries never match
    tq.push_back(ex(w(32'h00000000), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'h00000000), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'h00000000), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'h00000000), 2, 1, 32'h00000000, 0, 0, 0, 0));
    tq.push_back(ex(clr_v(), 1, 0, 0, 0, 0, 0, 0));

    // Offset 0
    tq.push_back(ex(cfg_v(1, 48'h01B2C3D4E5F6, 1, 6'h3f), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'h01B2C3D4), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'hE5F60000), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'h00000000), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'h00000000), 2, 1, 32'h01B2C3D4, 4'b0010, 1, 0, 4'b0010));
    tq.push_back(ex(w(32'h00000000), 2, 1, 32'hE5F60000, 4'b0000, 0, 0, 4'b0010));
    tq.push_back(ex(clr_v(), 3, 0, 32'hE5F60000, 0, 0, 0, 0));

    // Offset 3 with idle gaps
    tq.push_back(ex(w(32'h00000001), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(idle_v(), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'hB2C3D4E5), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(idle_v(), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'hF6000000), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(idle_v(), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'h00000000), 2, 1, 32'h00000001, 4'b0010, 1, 3, 4'b0010));
    tq.push_back(ex(idle_v(), 3, 0, 32'h00000001, 0, 0, 0, 4'b0010));
    tq.push_back(ex(clr_v(), 1, 0, 0, 0, 0, 0, 0));

    // Multi-entry hit and sticky persistence
    tq.push_back(ex(cfg_v(0, 48'hFFFFFFFFFFFF, 1, 6'h3f), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(cfg_v(2, 48'hFFFFFFFFFFFF, 1, 6'h3f), 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tq.push_back(ex(w(32'hFFFFFFFF), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'hFFFFFFFF), 2, 1, 32'hFFFFFFFF, 4'b0101, 0, 0, 4'b0101));
    tq.push_back(ex(idle_v(), 1, 0, 0, 0, 0, 0, 4'b0101));
    tq.push_back(ex(idle_v(), 1, 0, 0, 0, 0, 0, 4'b0101));
    tq.push_back(ex(clr_v(), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(cfg_v(0, 48'hFFFFFFFFFFFF, 0, 6'h3f), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(cfg_v(2, 48'hFFFFFFFFFFFF, 0, 6'h3f), 1, 0, 0, 0, 0, 0, 0));

    // Disable entry 1 in the same cycle its address is compared
    tq.push_back(ex(w(32'h01B2C3D4), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'hE5F60000), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'h00000000), 1, 0, 0, 0, 0, 0, 0));
    v = w(32'h00000000);
    v.we = 1'b1; v.idx = 2'd1; v.mac = 48'h01B2C3D4E5F6; v.en = 1'b0;
    tq.push_back(ex(v, 2, 1, 32'h01B2C3D4, 4'b0010, 1, 0, 4'b0010));
    tq.push_back(ex(clr_v(), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'h01B2C3D4), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'hE5F60000), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'h00000000), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'h00000000), 2, 1, 32'h01B2C3D4, 4'b0000, 0, 0, 4'b0000));
    tq.push_back(ex(clr_v(), 1, 0, 0, 0, 0, 0, 0));

    // OUI mask on entry 3
    tq.push_back(ex(cfg_v(3, 48'h01B2C3000000, 1, 6'h38), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'h01B2C3AA), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'hBBCC0000), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'h00000000), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'h00000000), 2, 1, 32'h01B2C3AA, E_MASK_VEC, E_MASK_IDX, 0, E_MASK_ST));
    tq.push_back(ex(clr_v(), 1, 0, 0, 0, 0, 0, 0));

    // clear in the same cycle as in_valid discards the word
    v = clr_v(); v.iv = 1'b1; v.data = 32'h12345678;
    tq.push_back(ex(v, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tq.push_back(ex(w(32'h00000000), 1, 0, 0, 0, 0, 0, 0));
    tq.push_back(ex(w(32'h00000000), 2, 1, 32'h00000000, 0, 0, 0, 0));

    for (int r = 0; r < tq.size(); r++) begin
      apply(tq[r]);
      check_row(tq[r], r);
    end

    // Randomized traffic against the reference model
    pool[0] = 48'h01B2C3D4E5F6;
    pool[1] = 48'hFFFFFFFFFFFF;
    pool[2] = {16'($urandom_range(0, 65535)), 32'($urandom)};
    pool[3] = 48'hAABBCCDDEEFF;
    for (int e = 0; e < N; e++) begin
      apply(cfg_v(2'(e), pool[e], 1'b1, rnd_mask()));
      check_model(-1 - e);
    end
    for (int c = 0; c < 800; c++) begin
      int r;
      v = idle_v();
      r = $urandom_range(0, 99);
      if (r < 2) v.clr = 1'b1;
      if (r < 72) begin
        v.iv = 1'b1;
        v.data = next_word();
      end
      if ($urandom_range(0, 99) < 8) begin
        v.we   = 1'b1;
        v.idx  = 2'($urandom_range(0, N - 1));
        v.mac  = pool[$urandom_range(0, 3)];
        v.en   = ($urandom_range(0, 3) != 0);
        v.mask = rnd_mask();
      end
      apply(v);
      check_model(c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_filter_bank.md
# mac_filter_bank

Multi-entry, programmable successor to the single-address MAC comparator. It sits in the sniffer datapath after the word assembler. It scans a 32-bit byte stream for any of NUM_MACS 48-bit addresses at any byte alignment. Each word is forwarded unchanged, three accepted words later, with per-entry match flags aligned to the word that holds the address's first byte. The table is written at runtime through a simple config port; sticky hit bits feed the alert logic.

## Interface
- NUM_MACS, 4, number of table entries (1..16)
- IDX_W, $clog2(NUM_MACS) (min 1), entry index width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush of window, output and sticky bits; table untouched
- in_valid  in  1  data_in holds an accepted stream word this cycle
- data_in  in  32  stream word, first byte in [31:24]
- cfg_we  in  1  write table entry cfg_idx
- cfg_idx  in  IDX_W  entry to write
- cfg_mac  in  48  address, first byte in [47:40]
- cfg_en  in  1  entry enable
- cfg_mask  in  6  per-byte compare enable, bit 5 = first byte (only with MAC_FILTER_MASK_EN)
- out_valid  out  1  data_out/match fields valid
- data_out  out  32  delayed stream word
- match  out  1  OR of match_vec, qualified by out_valid
- match_vec  out  NUM_MACS  per-entry hit for this output word
- match_idx  out  IDX_W  lowest set index of match_vec, 0 if none
- match_offset  out  2  byte offset of the address start within data_out
- sticky_hit  out  NUM_MACS  accumulated hits since reset/clear

## Operation
- Window of three words W0 (newest), W1, W2 (oldest), each with a valid bit; shifts only on in_valid.
- Candidate k (0..3) = {W2,W1,W0}[95-8k -: 48]; entry e hits at k when enabled, all three valid, and candidate equals cfg_mac (masked bytes ignored when the macro is defined).
- Several offsets hit: report the lowest k; match_vec bit e = entry e hit at any k.
- On in_valid with W2 valid: register W2 into data_out, assert out_valid with the computed hit vector, offset and index. match_idx and match_offset are taken from the lowest hitting entry.
- No in_valid: out_valid = 0 and the window holds; data_out retains the last word.
- Table write: entry updated at the edge; it is used for comparisons from the next cycle. The same-cycle comparison uses the old value.
- sticky_hit |= match_vec whenever out_valid.
- clear: all window valids, out_valid, match fields and sticky_hit go to 0 at the edge. clear with in_valid in the same cycle discards the word (clear wins). cfg_we in the same cycle still writes.
- rst: as clear, plus every entry gets en = 0, mac = 0 and mask = all-ones. data_out = 0.
- An address spanning the final words is never reported until three more words push it out; the upstream block flushes with zero words.

## Timing
- Reset values: every output 0.
- Latency: word N appears on data_out in the cycle after word N+3 is accepted, independent of gaps in in_valid.
- All outputs are registered; the comparison is a single combinational level over the window feeding the output register.
- Throughput: one word per cycle.

## Configuration
- MAC_FILTER_MASK_EN defined: the cfg_mask port and per-entry 6-bit mask storage exist. A cleared mask bit makes that byte don't-care, so mask 6'b111000 gives an OUI match. A mask of all zeros never hits.
- MAC_FILTER_MASK_EN undefined: the cfg_mask port is absent and all 48 bits are compared.

## Structure
- sniffer_pkg: mac_t (48-bit), mac_mask_t (6-bit), MAC_WIN_WORDS = 3, MAC_OFFSETS = 4.
- One sub-module, mac_filter_entry: it holds one entry's registers and takes the 96-bit window. It outputs hit and the lowest-offset hit. The top generates NUM_MACS instances and a priority encoder.

## Test plan
- Reset: rst high 2 cycles, then idle -> all outputs 0, sticky_hit 0, no match on any traffic (entries disabled).
- Offset 0: entry 1 = 01B2C3D4E5F6 enabled; stream 01B2C3D4, E5F60000, 0, 0, 0 -> first out word 01B2C3D4 with match=1, match_vec=4'b0010, match_idx=1, offset 0; next word E5F60000 with match=0.
- Offset 3 with gaps: stream 00000001, B2C3D4E5, F6000000, 0 with one idle cycle between each -> 00000001 out with offset 3, match=1; out_valid only the cycle after each accept.
- Multi-entry: entry 0 = FFFFFFFFFFFF, entry 2 = same; stream all-ones x4 -> match_vec=4'b0101, match_idx=0, offset 0; sticky_hit=4'b0101 persists until clear pulse, then 0.
- Table update/disable: write entry 1 disabled while its address is in the window -> the word emitted next still matches (old value); a repeat of the stream afterwards gives no match.
- Mask (macro on): entry 3 = 01B2C3000000, mask 111000; stream 01B2C3AA, BBCC0000, 0, 0 -> match_idx=3, offset 0; with the macro off, no match.
